// File: rtl/shift_register_sipo_rx.sv
// ---------------------------------------------------------------------------
// shift_register_sipo_rx
//
// Serial-in, parallel-out deserializer. Rebuilds N-bit words from a serial
// stream sent MSB first (the order a PISO emits tmp[N-1] first). Completed
// words are held in an output register with a valid/ready handshake. An
// optional start strobe aligns the word boundary, and a sticky overrun flag
// records words dropped because the consumer was not ready.
//
// Parameters:
//   N        word width in bits (N >= 2)
//   SYNC_REQ 1: ignore serial bits after reset until the first start
//            0: begin assembling immediately after reset
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   SI        serial data bit
//   SI_valid  SI is sampled only when this is high
//   start     marks the current (or next) valid bit as the MSB of a word
//   PO        assembled word, MSB = first bit received
//   PO_valid  PO holds an unconsumed word
//   PO_ready  consumer accepts PO when PO_valid && PO_ready
//   overrun   sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module shift_register_sipo_rx #(
    parameter int N        = 8,
    parameter bit SYNC_REQ = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         SI,
    input  logic         SI_valid,
    input  logic         start,
    output logic [N-1:0] PO,
    output logic         PO_valid,
    input  logic         PO_ready,
    output logic         overrun
);

    localparam int CNT_W = $clog2(N);

    typedef enum logic {
        HUNT,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [N-1:0]     sh;
    logic [N-1:0]     sh_nxt;
    logic             word_done;
    logic [N-1:0]     word;

    // The finished word includes the bit arriving this cycle, so it is formed
    // from the shift register plus SI rather than waiting a cycle for sh.
    assign word = {sh[N-2:0], SI};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC_REQ ? HUNT : SHIFT;
            cnt   <= '0;
            sh    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sh    <= sh_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        word_done = 1'b0;

        case (state)
            HUNT: begin
                if (start) begin
                    state_nxt = SHIFT;
                    if (SI_valid) begin
                        sh_nxt  = {sh[N-2:0], SI};
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        cnt_nxt = '0;
                    end
                end
            end

            SHIFT: begin
                if (start) begin
                    // A start inside a word throws away the partial word; the
                    // stale upper bits of sh are shifted out before the next
                    // completion, so only cnt needs restarting.
                    if (SI_valid) begin
                        sh_nxt  = {sh[N-2:0], SI};
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        cnt_nxt = '0;
                    end
                end else if (SI_valid) begin
                    sh_nxt = {sh[N-2:0], SI};
                    if (cnt == CNT_W'(N - 1)) begin
                        word_done = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = HUNT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output holding register. A word completing while the held word is being
    // consumed replaces it in the same cycle, which keeps streaming bubble-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            PO       <= '0;
            PO_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (word_done) begin
            if (!PO_valid || PO_ready) begin
                PO       <= word;
                PO_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (PO_valid && PO_ready) begin
            PO_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_register_sipo_rx.sv
// ---------------------------------------------------------------------------
// tb_shift_register_sipo_rx
//
// Self-checking bench for shift_register_sipo_rx (N=8). The main instance
// uses SYNC_REQ=1 and is compared every cycle against a word-level reference
// model (a queue of received bits per frame). A second instance with
// SYNC_REQ=0 is fed from a PISO model for the loopback case.
// ---------------------------------------------------------------------------
module tb_shift_register_sipo_rx;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, start, SI_valid, SI, PO_ready;
    logic [N-1:0] PO;
    logic         PO_valid, overrun;

    logic         rst0, start0, siv0, si0, ready0;
    logic [N-1:0] po0;
    logic         pv0, ov0;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit           m_sync;
    bit           m_bits[$];
    logic [N-1:0] m_po;
    logic         m_pv;
    logic         m_ov;

    always #5 clk = ~clk;

    shift_register_sipo_rx #(.N(N), .SYNC_REQ(1'b1)) dut (
        .clk(clk), .rst(rst), .SI(SI), .SI_valid(SI_valid), .start(start),
        .PO(PO), .PO_valid(PO_valid), .PO_ready(PO_ready), .overrun(overrun)
    );

    shift_register_sipo_rx #(.N(N), .SYNC_REQ(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .SI(si0), .SI_valid(siv0), .start(start0),
        .PO(po0), .PO_valid(pv0), .PO_ready(ready0), .overrun(ov0)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the rules at word level.
    task automatic model_step(input logic r, input logic st, input logic v,
                              input logic s, input logic rd);
        logic [N-1:0] w;
        bit           done;
        done = 0;
        w    = '0;
        if (r) begin
            m_bits.delete();
            m_sync = 1'b0;
            m_po   = '0;
            m_pv   = 1'b0;
            m_ov   = 1'b0;
        end else begin
            if (st) begin
                m_bits.delete();
                m_sync = 1'b1;
                if (v) m_bits.push_back(s);
            end else if (m_sync && v) begin
                m_bits.push_back(s);
                if (m_bits.size() == N) begin
                    foreach (m_bits[i]) w = {w[N-2:0], m_bits[i]};
                    m_bits.delete();
                    done = 1;
                end
            end
            if (done) begin
                if (!m_pv || rd) begin
                    m_po = w;
                    m_pv = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (m_pv && rd) begin
                m_pv = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic st, input logic v,
                        input logic s, input logic rd);
        rst      = r;
        start    = st;
        SI_valid = v;
        SI       = s;
        PO_ready = rd;
        model_step(r, st, v, s, rd);
        @(posedge clk);
        #1;
        check_eq("po", 32'(PO), 32'(m_po));
        check_eq("po_valid", 32'(PO_valid), 32'(m_pv));
        check_eq("overrun", 32'(overrun), 32'(m_ov));
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic with_start,
                             input logic rd, input int max_gap);
        for (int i = N - 1; i >= 0; i--) begin
            if (i != N - 1) begin
                int gap;
                gap = $urandom_range(0, max_gap);
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'($urandom), rd);
            end
            step(1'b0, with_start && (i == N - 1), 1'b1, w[i], rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] stream [3];
        logic [N-1:0] piso;

        stream[0] = 8'h3C;
        stream[1] = 8'hFF;
        stream[2] = 8'h01;

        rst0 = 1'b1; start0 = 1'b0; siv0 = 1'b0; si0 = 1'b0; ready0 = 1'b0;
        rst = 1'b1; start = 1'b0; SI_valid = 1'b0; SI = 1'b0; PO_ready = 1'b0;
        #1;

        // reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("rst_po", 32'(PO), 32'h0);
        check_eq("rst_po_valid", 32'(PO_valid), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);

        // hunt: bits without start are ignored
        for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b1);
        check_eq("hunt_po_valid", 32'(PO_valid), 32'h0);
        send_word(8'hA5, 1'b1, 1'b0, 0);
        check_eq("hunt_a5_po", 32'(PO), 32'hA5);
        check_eq("hunt_a5_valid", 32'(PO_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("hunt_consumed", 32'(PO_valid), 32'h0);

        // streaming back-to-back with consumer always ready
        for (int k = 0; k < 3; k++) begin
            send_word(stream[k], 1'b0, 1'b1, 0);
            check_eq("stream_po", 32'(PO), 32'(stream[k]));
            check_eq("stream_valid", 32'(PO_valid), 32'h1);
        end
        check_eq("stream_overrun", 32'(overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // stalls between bits
        send_word(8'h96, 1'b0, 1'b0, 3);
        check_eq("stall_po", 32'(PO), 32'h96);
        check_eq("stall_valid", 32'(PO_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // resync after junk
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
        check_eq("resync_no_word", 32'(PO_valid), 32'h0);
        send_word(8'h5A, 1'b1, 1'b0, 0);
        check_eq("resync_po", 32'(PO), 32'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // overrun under back-pressure
        send_word(8'h11, 1'b0, 1'b0, 1);
        send_word(8'h22, 1'b0, 1'b0, 1);
        check_eq("ovr_po", 32'(PO), 32'h11);
        check_eq("ovr_flag", 32'(overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ovr_consumed", 32'(PO_valid), 32'h0);
        check_eq("ovr_sticky", 32'(overrun), 32'h1);

        // reset mid-word
        send_word(8'h77, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("midrst_po", 32'(PO), 32'h0);
        check_eq("midrst_valid", 32'(PO_valid), 32'h0);
        check_eq("midrst_overrun", 32'(overrun), 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end

        // PISO loopback into the SYNC_REQ=0 instance
        rst0 = 1'b0;
        @(posedge clk); #1;
        piso = 8'hC3;
        ready0 = 1'b0;
        for (int i = 0; i < N; i++) begin
            si0    = piso[N-1];
            siv0   = 1'b1;
            start0 = (i == 0);
            @(posedge clk); #1;
            piso = {piso[N-2:0], 1'b0};
        end
        siv0 = 1'b0; start0 = 1'b0;
        check_eq("loop_po", 32'(po0), 32'hC3);
        check_eq("loop_valid", 32'(pv0), 32'h1);
        check_eq("loop_overrun", 32'(ov0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
